// File: rtl/pwl_arb_pkg.sv
// Shared types and helpers for the PWL evaluator arbiter: ID sizing,
// response entry layout and the round-robin selector.
package pwl_arb_pkg;

   localparam int MAX_REQ    = 16;
   localparam int ID_W_MAX   = 4;
   localparam int DATA_W_MAX = 32;

   typedef struct packed {
      logic [ID_W_MAX-1:0]          id;
      logic signed [DATA_W_MAX-1:0] data;
   } rsp_entry_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First set bit at or above ptr, wrapping at n; -1 when nothing is set.
   function automatic int rr_select(input logic [MAX_REQ-1:0] vld, input int n, input int ptr);
      int idx;
      int sel;
      sel = -1;
      for (int k = MAX_REQ-1; k >= 0; k--) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (vld[idx]) sel = idx;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/pwl_rsp_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head is visible on dout
// whenever empty is low.
module pwl_rsp_fifo
   import pwl_arb_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [W-1:0]                 din,
   input  logic                         pop,
   output logic [W-1:0]                 dout,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (int'(p) == DEPTH-1) ? '0 : p + 1'b1;
   endfunction

   assign empty  = (cnt_q == '0);
   assign full   = (int'(cnt_q) == DEPTH);
   assign count  = cnt_q;
   assign dout   = mem[rd_q];
   assign do_pop = pop && !empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push)   wr_q <= inc(wr_q);
         if (do_pop) rd_q <= inc(rd_q);
         cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
      end
   end

   // Upstream credit accounting must never let a push land on a full FIFO.
   a_no_push_on_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !do_pop));

endmodule

// File: rtl/pwl_arbiter.sv
// Round-robin arbiter sharing one PWL evaluator among NUM_REQ requesters,
// with credit-gated grants and a result FIFO. PWL_ARB_STATS_EN adds grant_cnt.
module pwl_arbiter
   import pwl_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 18,
   parameter int PWL_LAT   = 1,
   parameter int RSP_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ*IN_WIDTH-1:0]       req_in,
   output logic [NUM_REQ-1:0]                req_ready,
   output logic [IN_WIDTH-1:0]               pwl_in,
   input  logic signed [OUT_WIDTH-1:0]       pwl_out,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [id_width(NUM_REQ)-1:0]      rsp_id,
   output logic signed [OUT_WIDTH-1:0]       rsp_data
`ifdef PWL_ARB_STATS_EN
   ,output logic [NUM_REQ*16-1:0]            grant_cnt
`endif
);
   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = $clog2(RSP_DEPTH+1);
   localparam int E_W   = ID_W + OUT_WIDTH;

   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [IN_WIDTH-1:0] pwl_in_q;
   logic [PWL_LAT-1:0]  tag_vld_q;
   logic [ID_W-1:0]     tag_id_q [PWL_LAT];

   logic                grant;
   logic [ID_W-1:0]     gnt_id;
   logic [IN_WIDTH-1:0] gnt_data;
   int                  sel;
   int                  used;

   logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [E_W-1:0]      fifo_din, fifo_head;

   // A pop this cycle frees its slot for a grant issued in the same cycle.
   always_comb begin
      used = int'(fifo_cnt) - int'(fifo_pop);
      for (int s = 0; s < PWL_LAT; s++) begin
         if (tag_vld_q[s]) used = used + 1;
      end
      sel      = rr_select(MAX_REQ'(req_valid), NUM_REQ, int'(ptr_q));
      grant    = rst_n && (sel >= 0) && (used < RSP_DEPTH);
      gnt_id   = '0;
      gnt_data = pwl_in_q;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant && sel == i) begin
            req_ready[i] = 1'b1;
            gnt_id       = ID_W'(i);
            gnt_data     = req_in[i*IN_WIDTH +: IN_WIDTH];
         end
      end
      ptr_d = ptr_q;
      if (grant) ptr_d = (int'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + 1'b1;
   end

   assign pwl_in = gnt_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         pwl_in_q  <= '0;
         tag_vld_q <= '0;
         for (int s = 0; s < PWL_LAT; s++) tag_id_q[s] <= '0;
      end else begin
         ptr_q        <= ptr_d;
         pwl_in_q     <= gnt_data;
         tag_vld_q[0] <= grant;
         tag_id_q[0]  <= gnt_id;
         for (int s = 1; s < PWL_LAT; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_id_q[s]  <= tag_id_q[s-1];
         end
      end
   end

   assign fifo_push = tag_vld_q[PWL_LAT-1];
   assign fifo_din  = {tag_id_q[PWL_LAT-1], pwl_out};
   assign fifo_pop  = !fifo_empty && rsp_ready;

   pwl_rsp_fifo #(
      .W     (E_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_cnt)
   );

   // Storage is not reset, so the head is masked to zero while empty.
   assign rsp_valid = !fifo_empty;
   assign rsp_id    = fifo_empty ? '0 : fifo_head[E_W-1 -: ID_W];
   assign rsp_data  = fifo_empty ? '0 : $signed(fifo_head[OUT_WIDTH-1:0]);

`ifdef PWL_ARB_STATS_EN
   logic [15:0] gcnt_q [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && gcnt_q[i] != 16'hFFFF) gcnt_q[i] <= gcnt_q[i] + 16'd1;
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = gcnt_q[i];
   end
`endif

endmodule

// File: tb/tb_pwl_arbiter.sv
// Scoreboard bench for pwl_arbiter: a behavioural PWL evaluator feeds the DUT,
// expected {id, data} entries are queued on grant and compared on pop.
module tb_pwl_arbiter;
   import pwl_arb_pkg::*;

   localparam int NREQ = 4;
   localparam int INW  = 16;
   localparam int OUTW = 18;
   localparam int LAT  = 1;
   localparam int DEP  = 4;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*INW-1:0]    req_in;
   logic [NREQ-1:0]        req_ready;
   logic [INW-1:0]         pwl_in;
   logic signed [OUTW-1:0] pwl_out;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [1:0]             rsp_id;
   logic signed [OUTW-1:0] rsp_data;
`ifdef PWL_ARB_STATS_EN
   logic [NREQ*16-1:0]     grant_cnt;
`endif

   int         n_vec = 0;
   int         n_err = 0;
   int         g_cnt = 0;
   int         g_base;
   rsp_entry_t sb [$];
   rsp_entry_t e_m;

   always #5 clk = ~clk;

   pwl_arbiter #(
      .NUM_REQ(NREQ), .IN_WIDTH(INW), .OUT_WIDTH(OUTW), .PWL_LAT(LAT), .RSP_DEPTH(DEP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_in    (req_in),
      .req_ready (req_ready),
      .pwl_in    (pwl_in),
      .pwl_out   (pwl_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
`ifdef PWL_ARB_STATS_EN
      ,.grant_cnt (grant_cnt)
`endif
   );

   // Three-segment transfer curve standing in for the ROM-based evaluator.
   function automatic logic signed [OUTW-1:0] eval_f(input logic [INW-1:0] x);
      int xi, y;
      xi = int'(x);
      if (xi < 32'h4000)      y = xi;
      else if (xi < 32'hC000) y = 32'h4000 + (xi - 32'h4000) / 2;
      else                    y = 32'h8000 - (xi - 32'hC000) * 3;
      return OUTW'(y);
   endfunction

   logic signed [OUTW-1:0] eval_pipe [LAT];
   always @(posedge clk) begin
      eval_pipe[0] <= eval_f(pwl_in);
      for (int s = 1; s < LAT; s++) eval_pipe[s] <= eval_pipe[s-1];
   end
   assign pwl_out = eval_pipe[LAT-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) chk("unexpected_rsp", {62'b0, rsp_id}, 64'hDEAD);
            else begin
               e_m = sb.pop_front();
               chk("rsp_id", {62'b0, rsp_id}, {60'b0, e_m.id});
               chk("rsp_data", {46'b0, rsp_data}, {46'b0, e_m.data[OUTW-1:0]});
            end
         end
         chk("ready_wo_valid", {60'b0, req_ready & ~req_valid}, 64'd0);
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e_m.id   = 4'(i);
               e_m.data = 32'(eval_f(req_in[i*INW +: INW]));
               sb.push_back(e_m);
               g_cnt++;
            end
         end
      end
   end

   task automatic drain();
      for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
      chk("drain_empty", 64'(sb.size()), 64'd0);
      repeat (4) @(negedge clk);
      chk("idle_no_rsp", {63'b0, rsp_valid}, 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      req_in    = {16'hF000, 16'hA000, 16'h2345, 16'h0010};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready",  {60'b0, req_ready}, 64'd0);
      chk("rst_valid",  {63'b0, rsp_valid}, 64'd0);
      chk("rst_id",     {62'b0, rsp_id},    64'd0);
      chk("rst_data",   {46'b0, rsp_data},  64'd0);
      chk("rst_pwl_in", {48'b0, pwl_in},    64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_valid = '0;

      // Single request from requester 2.
      @(posedge clk); #1;
      req_in[2*INW +: INW] = 16'h0100;
      req_valid = 4'b0100;
      @(negedge clk);
      chk("single_ready", {60'b0, req_ready}, 64'h4);
      chk("single_pwl_in", {48'b0, pwl_in}, 64'h0100);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("single_lat_early", {63'b0, rsp_valid}, 64'd0);
      chk("pwl_in_hold", {48'b0, pwl_in}, 64'h0100);
      @(negedge clk);
      chk("single_lat_valid", {63'b0, rsp_valid}, 64'd1);
      chk("single_id", {62'b0, rsp_id}, 64'd2);
      chk("single_data", {46'b0, rsp_data}, 64'h100);
      drain();

      // Pointer now 3: requester 1 alone wraps; then 2 beats 1 at ptr 2.
      @(posedge clk); #1; req_valid = 4'b0010;
      @(negedge clk); chk("wrap_gnt", {60'b0, req_ready}, 64'h2);
      @(posedge clk); #1; req_valid = 4'b0110;
      @(negedge clk); chk("ptr_after_wrap", {60'b0, req_ready}, 64'h4);
      @(posedge clk); #1; req_valid = 4'b1000;
      @(negedge clk); chk("gnt3", {60'b0, req_ready}, 64'h8);

      // Continuous round robin from ptr 0.
      @(posedge clk); #1; req_valid = 4'hF;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("rr_seq", {60'b0, req_ready}, 64'(1 << (c % 4)));
         if (c >= 2) chk("rr_rsp_each_cycle", {63'b0, rsp_valid}, 64'd1);
      end
      @(posedge clk); #1; req_valid = '0;
      drain();

      // Backpressure: only RSP_DEPTH grants, then resume on first pop cycle.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      g_base = g_cnt;
      req_valid = 4'hF;
      repeat (10) @(negedge clk);
      @(posedge clk); #1;
      chk("bp_grants", 64'(g_cnt - g_base), 64'(DEP));
      chk("bp_ready_low", {60'b0, req_ready}, 64'd0);
      chk("bp_rsp_valid", {63'b0, rsp_valid}, 64'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_resume", {63'b0, |req_ready}, 64'd1);
      @(posedge clk); #1; req_valid = '0;
      drain();

      // Reset with 3 results buffered and 1 in flight.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_full", {63'b0, rsp_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {63'b0, rsp_valid}, 64'd0);
      chk("mid_rst_ready", {60'b0, req_ready}, 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 4'b0110;
      @(negedge clk);
      chk("post_rst_gnt", {60'b0, req_ready}, 64'h2);
      @(posedge clk); #1; req_valid = '0;
      drain();

`ifdef PWL_ARB_STATS_EN
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("cnt_rst", grant_cnt, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      g_base = g_cnt;
      req_valid = 4'b0001;
      repeat (1000) @(posedge clk);
      #1;
      chk("cnt_mid", {48'b0, grant_cnt[15:0]}, 64'(g_cnt - g_base));
      repeat (70000) @(posedge clk);
      #1;
      chk("cnt_sat", {48'b0, grant_cnt[15:0]}, 64'hFFFF);
      chk("cnt_others", {16'b0, grant_cnt[63:16]}, 64'd0);
      req_valid = '0;
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pwl_arbiter.md
Name: pwl_arbiter

Overview:
- Shares one piecewise-linear evaluator (single ROM + multiplier; fixed pipeline latency) among NUM_REQ requesters, e.g. per-tap step-response lookups in the channel emulator.
- Round-robin grant per cycle; tags each issued input with the requester ID.
- Aligns the tag with the evaluator latency and buffers results in a small FIFO so the consumer can apply backpressure without dropping data.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- IN_WIDTH, 16, evaluator input width (fixed-point input word)
- OUT_WIDTH, 18, evaluator output width (signed)
- PWL_LAT, 1, evaluator latency in clocks from input to output (ROM read latency)
- RSP_DEPTH, 4, result FIFO depth; must be >= PWL_LAT+1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_in  in  NUM_REQ*IN_WIDTH  per-requester input; slice i = bits [i*IN_WIDTH +: IN_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; a request transfers when req_valid[i] && req_ready[i]
- pwl_in  out  IN_WIDTH  drive to evaluator input
- pwl_out  in  OUT_WIDTH  evaluator output, valid PWL_LAT cycles after pwl_in
- rsp_valid  out  1  head of result FIFO valid
- rsp_ready  in  1  consumer accepts the head entry
- rsp_id  out  $clog2(NUM_REQ)  requester ID of the head entry
- rsp_data  out  OUT_WIDTH  evaluator result of the head entry (signed)

Behaviour:
- Reset (asynchronous, rst_n=0): req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, pwl_in=0; RR pointer=0; tag pipeline invalid; FIFO empty.
- Credit: credits = RSP_DEPTH - fifo_count - inflight. A grant is issued only if credits>0, including on the same cycle a pop frees an entry.
- Grant: combinational. It selects the first i with req_valid[i], scanning from ptr upward with wrap. req_ready is 0 everywhere when there are no credits or no valid requests. req_ready never asserts toward a requester with req_valid=0.
- Pointer: after a grant to i, ptr <= (i+1) mod NUM_REQ. Without a grant, ptr holds.
- pwl_in = req_in slice of the granted requester. When idle it holds its last value; it must not toggle unnecessarily.
- Tag pipeline: PWL_LAT-stage shift of {valid, id}, aligned with the evaluator. On stage-PWL_LAT valid, push {id, pwl_out} into the FIFO.
- FIFO push and pop in the same cycle are legal.
- Credit accounting guarantees push-on-full never occurs. An assertion flags the violation.
- Output: show-ahead FIFO. rsp_* reflect the head; rsp_valid=!empty. Pop on rsp_valid && rsp_ready.
- Total latency from grant to earliest rsp_valid is PWL_LAT+1 cycles (FIFO registered write).
- Throughput: 1 result/cycle sustained when rsp_ready=1.
- Mid-operation reset clears all in-flight tags and FIFO contents. Evaluator outputs arriving after reset are ignored.
- NUM_REQ=1 is legal. The pointer is then constant 0.

Optional Feature:
- Macro: PWL_ARB_STATS_EN.
- Defined: adds output grant_cnt (NUM_REQ*16 bits), one saturating 16-bit counter per requester, incremented on each grant. Counters saturate at 0xFFFF. Reset clears them to 0.
- Undefined: no port and no counters; logic is identical otherwise.

Decomposition:
- Shared package pwl_arb_pkg:
  - function to compute ID width
  - typedef rsp_entry_t {id, data}
  - RR-select function (first set bit from pointer, with wrap)
- One sub-module: pwl_rsp_fifo (parameterised synchronous show-ahead FIFO with count output), instantiated once.

Test Plan:
- Single requester 2 sends input 0x0100 with rsp_ready=1 -> req_ready=4'b0100 that cycle; rsp_valid at +PWL_LAT+1 with rsp_id=2 and rsp_data equal to the evaluator model for 0x0100.
- All four requesters valid continuously, rsp_ready=1, ptr=0 -> grants 0,1,2,3,0,...; one result per cycle, IDs in the same order.
- Backpressure: rsp_ready=0 with all requesters valid -> exactly RSP_DEPTH=4 grants, then req_ready=0. Release rsp_ready -> grants resume on the first pop cycle with no lost or duplicated results.
- Requester 1 only, ptr=3 after a grant to 2 -> wrap search grants 1; ptr becomes 2.
- rst_n asserted low while 3 results are buffered and 1 is in flight -> immediately rsp_valid=0 and req_ready=0. After release, the first grant goes to the lowest valid index, and no stale result emerges.
- With PWL_ARB_STATS_EN: 70000 grants to requester 0 -> grant_cnt[0] saturates at 0xFFFF; other counters stay 0.
